bitrev_stream_ctrl: RTL and testbench

//  Streaming bit-reversal reorder controller for the NTT/INTT datapath.

---
 rtl/bitrev_stream_ctrl.sv | 94 +++++++++
 tb/tb_bitrev_stream_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_stream_ctrl.sv
// Streaming bit-reversal reorder buffer: serial coefficients in natural order are
// collected into a ping-pong bank pair and replayed in bit-reversed or natural order.
module bitrev_stream_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 16,
    localparam int unsigned LOGN      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  rev_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [LOGN-1:0]       m_idx,
    output logic                  busy
);

    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    logic [DATA_WIDTH-1:0] mem [2][N];
    logic [1:0]            full;
    logic [1:0]            mode;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [LOGN-1:0]       wr_cnt;
    logic [LOGN-1:0]       rd_cnt;
    logic                  s_fire;
    logic                  m_fire;
    logic                  wr_done;
    logic                  rd_done;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOGN; i++) begin
            r[i] = x[LOGN-1-i];
        end
        return r;
    endfunction

    assign s_ready = !full[wr_bank];
    assign m_valid = full[rd_bank];
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;
    assign wr_done = s_fire && (wr_cnt == LAST_IDX);
    assign rd_done = m_fire && (rd_cnt == LAST_IDX);

    assign m_idx  = mode[rd_bank] ? bitrev(rd_cnt) : rd_cnt;
    assign m_data = mem[rd_bank][m_idx];
    assign m_last = m_valid && (rd_cnt == LAST_IDX);
    assign busy   = (|full) || (wr_cnt != '0);

    // Write and read pointers; fill and free always target different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= '0;
            mode    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (s_fire) begin
                wr_cnt <= wr_cnt + LOGN'(1);
            end
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
                mode[wr_bank] <= rev_en;
                wr_cnt        <= '0;
                wr_bank       <= !wr_bank;
            end
            if (m_fire) begin
                rd_cnt <= rd_cnt + LOGN'(1);
            end
            if (rd_done) begin
                full[rd_bank] <= 1'b0;
                rd_cnt        <= '0;
                rd_bank       <= !rd_bank;
            end
        end
    end

    // Coefficient storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            mem[wr_bank][wr_cnt] <= s_data;
        end
    end

endmodule

// File: tb/tb_bitrev_stream_ctrl.sv
// Scoreboard bench for bitrev_stream_ctrl: frames are modelled on input acceptance
// and each output beat is popped and compared in a negedge monitor.
module tb_bitrev_stream_ctrl;

    localparam int unsigned DW   = 16;
    localparam int unsigned N    = 16;
    localparam int unsigned LOGN = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic            rev_en = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic [LOGN-1:0] m_idx;
    logic            busy;

    typedef struct packed {
        logic [DW-1:0]   d;
        logic [LOGN-1:0] idx;
        logic            last;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         mb;
    beat_t         held;
    logic          held_v = 1'b0;
    logic [DW-1:0] in_frame [N];
    int            in_cnt = 0;
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    bitrev_stream_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .rev_en(rev_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_idx(m_idx), .busy(busy)
    );

    function automatic logic [LOGN-1:0] rev4(input logic [LOGN-1:0] k);
        logic [LOGN-1:0] r;
        r = {<<{k}};
        return r;
    endfunction

    // Handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_cnt = 0;
            held_v = 1'b0;
        end else begin
            if (s_valid && s_ready) begin
                in_frame[in_cnt] = s_data;
                if (in_cnt == int'(N) - 1) begin
                    for (int k = 0; k < int'(N); k++) begin
                        mb.idx  = rev_en ? rev4(LOGN'(k)) : LOGN'(k);
                        mb.d    = in_frame[mb.idx];
                        mb.last = (k == int'(N) - 1);
                        exp_q.push_back(mb);
                    end
                    in_cnt = 0;
                end else begin
                    in_cnt++;
                end
            end
            if (held_v) begin
                vectors++;
                if (!m_valid || {m_data, m_idx, m_last} !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b %h, required valid=1 %h",
                             m_valid, {m_data, m_idx, m_last}, held);
                end
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL out_beat: got data=%h idx=%0d last=%b, required no beat",
                             m_data, m_idx, m_last);
                end else begin
                    mb = exp_q.pop_front();
                    if ({m_data, m_idx, m_last} !== mb) begin
                        miscompares++;
                        $display("FAIL out_beat: got data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                                 m_data, m_idx, m_last, mb.d, mb.idx, mb.last);
                    end
                end
            end
            held_v = m_valid && !m_ready;
            held   = {m_data, m_idx, m_last};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic rev, input logic mr,
                             output int waits);
        s_valid = 1'b1;
        s_data  = d;
        rev_en  = rev;
        m_ready = mr;
        waits   = 0;
        #1;
        while (!s_ready && waits < 200) begin
            tick();
            waits++;
        end
        if (!s_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: got s_ready=0 for %0d cycles, required 1", waits);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: got %0d beats pending m_valid=%b, required 0 pending m_valid=0",
                     exp_q.size(), m_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({s_ready, m_valid, busy, m_last, m_idx} !== 8'b1000_0000) begin
                miscompares++;
                $display("FAIL idle_outputs: got rdy,vld,busy,last,idx=%b, required 10000000",
                         {s_ready, m_valid, busy, m_last, m_idx});
            end
            tick();
        end
    endtask

    task automatic test_single_frame();
        int w;
        for (int i = 0; i < 15; i++) begin
            push_word(DW'(i), 1'b1, 1'b1, w);
            if (i == 2) begin
                vectors++;
                if ({busy, m_valid} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL partial_busy: got busy,vld=%b, required 10", {busy, m_valid});
                end
            end
        end
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL early_valid: got m_valid=%b, required 0", m_valid);
        end
        push_word(DW'(15), 1'b1, 1'b1, w);
        vectors++;
        if ({m_valid, m_data} !== {1'b1, DW'(0)}) begin
            miscompares++;
            $display("FAIL latency: got vld=%b data=%0d, required vld=1 data=0", m_valid, m_data);
        end
        m_ready = 1'b1;
        tick();
        vectors++;
        if (m_data !== DW'(8) || m_idx !== LOGN'(8)) begin
            miscompares++;
            $display("FAIL second_beat: got data=%0d idx=%0d, required 8 8", m_data, m_idx);
        end
        wait_drain();
    endtask

    task automatic test_mode_per_frame();
        int w;
        for (int i = 0; i < 16; i++) push_word(DW'(100 + i), 1'b0, 1'b1, w);
        vectors++;
        if (m_data !== DW'(100) || m_idx !== LOGN'(0)) begin
            miscompares++;
            $display("FAIL natural_first: got data=%0d idx=%0d, required 100 0", m_data, m_idx);
        end
        for (int i = 0; i < 16; i++) push_word(DW'(200 + i), 1'b1, 1'b1, w);
        // rev_en only counts on the closing beat of a frame
        for (int i = 0; i < 16; i++) push_word(DW'(400 + i), (i != 15), 1'b1, w);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int w;
        for (int i = 0; i < 32; i++) push_word(DW'(300 + i), 1'b1, 1'b0, w);
        vectors++;
        if ({s_ready, m_valid, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL both_full: got rdy,vld,busy=%b, required 011", {s_ready, m_valid, busy});
        end
        push_word(DW'(332), 1'b1, 1'b1, w);
        vectors++;
        if (w != 16) begin
            miscompares++;
            $display("FAIL freed_bank: got %0d stall cycles, required 16", w);
        end
        for (int i = 1; i < 16; i++) push_word(DW'(332 + i), 1'b1, 1'b1, w);
        wait_drain();
    endtask

    task automatic test_random_stall();
        int sent;
        int c;
        sent = 0;
        c    = 0;
        rev_en = 1'b1;
        while ((sent < 320 || exp_q.size() != 0) && c < 5000) begin
            s_valid = (sent < 320) && ($urandom_range(0, 1) == 1);
            s_data  = DW'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (s_valid && s_ready) sent++;
            tick();
            c++;
        end
        vectors++;
        if (sent != 320) begin
            miscompares++;
            $display("FAIL random_inputs: got %0d accepted, required 320", sent);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_op();
        int w;
        for (int i = 0; i < 16; i++) push_word(DW'(500 + i), 1'b1, 1'b0, w);
        for (int i = 0; i < 7; i++) push_word(DW'(600 + i), 1'b1, 1'b0, w);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        m_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({m_valid, s_ready, busy, m_idx} !== 7'b0100000) begin
            miscompares++;
            $display("FAIL reset_mid: got vld,rdy,busy,idx=%b, required 0100000",
                     {m_valid, s_ready, busy, m_idx});
        end
        for (int i = 0; i < 16; i++) push_word(DW'(700 + i), 1'b1, 1'b1, w);
        vectors++;
        if ({m_valid, m_idx, m_data} !== {1'b1, LOGN'(0), DW'(700)}) begin
            miscompares++;
            $display("FAIL fresh_frame: got vld=%b idx=%0d data=%0d, required 1 0 700",
                     m_valid, m_idx, m_data);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_mode_per_frame();
        test_backpressure();
        test_random_stall();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
